// File: rtl/sync_ram_pkg.sv
// Shared constants and clear-FSM encoding for the byte-enable dual-port RAM.
package sync_ram_pkg;

   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

endpackage

// File: rtl/sync_ram_be_core.sv
// Storage array with byte-enable write port and a registered read port that
// resolves same-address collisions as read-first or write-first.
module sync_ram_be_core
   import sync_ram_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int RD_MODE = RD_FIRST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_W/8-1:0]   i_wr_be,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_W-1:0]     i_rd_addr,
   output logic [DATA_W-1:0]     o_rd_data
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int BE_W  = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_merged;
   logic [DATA_W-1:0] w_rd_next;
   logic              w_collide;

   // NOTE: the array has no reset term; resetting it would turn RAM into flops. The clear sweep zeroes it.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (i_wr_be[i]) r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_old     = r_mem[i_rd_addr];
      w_merged  = w_old;
      for (int i = 0; i < BE_W; i++) begin
         if (i_wr_be[i]) w_merged[8*i +: 8] = i_wr_data[8*i +: 8];
      end
      w_collide = i_wr_en && i_rd_en && (i_wr_addr == i_rd_addr);
      w_rd_next = (RD_MODE == WR_FIRST && w_collide) ? w_merged : w_old;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= w_rd_next;
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_ram_dp_be.sv
// Simple dual-port RAM top: post-reset clear FSM, port gating while clearing,
// optional output register stage and the read-valid pulse pipeline.
module sync_ram_dp_be
   import sync_ram_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 3,
   parameter int RD_MODE      = RD_FIRST,
   parameter int OUT_REG      = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid
);

   localparam state_t            RST_STATE = (CLEAR_ON_RST != 0) ? INIT : READY;
   localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_rd_valid1;
   logic                w_core_wr_en;
   logic [ADDR_W-1:0]   w_core_wr_addr;
   logic [DATA_W/8-1:0] w_core_wr_be;
   logic [DATA_W-1:0]   w_core_wr_data;
   logic                w_core_rd_en;
   logic [DATA_W-1:0]   w_core_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RST_STATE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         INIT:    if (r_cnt == CNT_LAST) w_state_next = READY;
         READY:   w_state_next = READY;
         default: w_state_next = RST_STATE;
      endcase
   end

   // While clearing, the sweep owns the write port and the user ports are dropped.
   always_comb begin
      init_busy      = 1'b0;
      w_core_wr_en   = wr_en;
      w_core_wr_addr = wr_addr;
      w_core_wr_be   = wr_be;
      w_core_wr_data = wr_data;
      w_core_rd_en   = rd_en;
      if (r_state == INIT) begin
         init_busy      = 1'b1;
         w_core_wr_en   = 1'b1;
         w_core_wr_addr = r_cnt;
         w_core_wr_be   = '1;
         w_core_wr_data = '0;
         w_core_rd_en   = 1'b0;
      end
   end

   sync_ram_be_core #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RD_MODE (RD_MODE)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_core_wr_en),
      .i_wr_addr (w_core_wr_addr),
      .i_wr_be   (w_core_wr_be),
      .i_wr_data (w_core_wr_data),
      .i_rd_en   (w_core_rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (w_core_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_valid1 <= 1'b0;
      else        r_rd_valid1 <= w_core_rd_en;
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              r_rd_valid2;
         logic [DATA_W-1:0] r_rd_data2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rd_valid2 <= 1'b0;
               r_rd_data2  <= '0;
            end else begin
               r_rd_valid2 <= r_rd_valid1;
               if (r_rd_valid1) r_rd_data2 <= w_core_rd_data;
            end
         end

         assign rd_data  = r_rd_data2;
         assign rd_valid = r_rd_valid2;
      end else begin : g_no_out_reg
         assign rd_data  = w_core_rd_data;
         assign rd_valid = r_rd_valid1;
      end
   endgenerate

endmodule

// File: tb/tb_sync_ram_dp_be.sv
// Directed bench: two instances share stimulus -- A is read-first/latency 1,
// B is write-first/latency 2 -- both with the post-reset clear sweep.
module tb_sync_ram_dp_be;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [1:0]  wr_be;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [2:0]  rd_addr;

   logic        busy_a, valid_a, busy_b, valid_b;
   logic [15:0] data_a, data_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sync_ram_dp_be #(.DATA_W(16), .ADDR_W(3), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .init_busy(busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a)
   );

   sync_ram_dp_be #(.DATA_W(16), .ADDR_W(3), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .init_busy(busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] val(input int i);
      return 16'hC000 + 16'(i) * 16'h0111;
   endfunction

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;

      // Reset state
      tick(); tick();
      check("rst_busy_a", 16'(busy_a), 16'd1);
      check("rst_busy_b", 16'(busy_b), 16'd1);
      check("rst_data_a", data_a, 16'h0000);
      check("rst_data_b", data_b, 16'h0000);
      check("rst_valid_a", 16'(valid_a), 16'd0);
      check("rst_valid_b", 16'(valid_b), 16'd0);

      // Sweep: busy exactly 8 cycles; user writes/reads ignored meanwhile
      rst_n = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd0; wr_be = 2'b11; wr_data = 16'hFFFF;
      rd_en = 1'b1; rd_addr = 3'd0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("sweep_busy_a_%0d", i), 16'(busy_a), 16'd1);
         check($sformatf("sweep_busy_b_%0d", i), 16'(busy_b), 16'd1);
         tick();
         check($sformatf("sweep_valid_a_%0d", i), 16'(valid_a), 16'd0);
         check($sformatf("sweep_valid_b_%0d", i), 16'(valid_b), 16'd0);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      check("sweep_done_a", 16'(busy_a), 16'd0);
      check("sweep_done_b", 16'(busy_b), 16'd0);

      // All words read back as zero
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; rd_addr = 3'(i);
         tick();
         check($sformatf("zero_valid_a_%0d", i), 16'(valid_a), 16'd1);
         check($sformatf("zero_data_a_%0d", i), data_a, 16'h0000);
         check($sformatf("zero_valid_b_%0d", i), 16'(valid_b), (i > 0) ? 16'd1 : 16'd0);
      end
      rd_en = 1'b0;
      tick();
      check("zero_tail_valid_b", 16'(valid_b), 16'd1);
      check("zero_tail_data_b", data_b, 16'h0000);
      check("zero_tail_valid_a", 16'(valid_a), 16'd0);

      // Byte-enable merge and read latency
      wr_en = 1'b1; wr_addr = 3'd3; wr_be = 2'b11; wr_data = 16'hA5A5;
      tick();
      wr_be = 2'b10; wr_data = 16'h1234;
      tick();
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
      tick();
      rd_en = 1'b0;
      check("be_valid_a", 16'(valid_a), 16'd1);
      check("be_data_a", data_a, 16'h12A5);
      check("be_early_valid_b", 16'(valid_b), 16'd0);
      tick();
      check("be_idle_valid_a", 16'(valid_a), 16'd0);
      check("be_hold_data_a", data_a, 16'h12A5);
      check("be_valid_b", 16'(valid_b), 16'd1);
      check("be_data_b", data_b, 16'h12A5);
      tick();
      check("be_idle_valid_b", 16'(valid_b), 16'd0);
      check("be_hold_data_b", data_b, 16'h12A5);

      // Full-word collision: A read-first, B write-first
      wr_en = 1'b1; wr_addr = 3'd5; wr_be = 2'b11; wr_data = 16'h1111;
      tick();
      wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 3'd5;
      tick();
      check("col_data_a", data_a, 16'h1111);
      wr_en = 1'b0;
      tick();
      check("col_next_data_a", data_a, 16'h2222);
      check("col_valid_b", 16'(valid_b), 16'd1);
      check("col_data_b", data_b, 16'h2222);
      rd_en = 1'b0;
      tick();
      check("col_next_data_b", data_b, 16'h2222);

      // Partial collision: write-first returns the merged word
      wr_en = 1'b1; wr_be = 2'b01; wr_data = 16'h3344; rd_en = 1'b1; rd_addr = 3'd5;
      tick();
      check("pcol_data_a", data_a, 16'h2222);
      wr_en = 1'b0; rd_en = 1'b0;
      tick();
      check("pcol_valid_b", 16'(valid_b), 16'd1);
      check("pcol_data_b", data_b, 16'h2244);
      rd_en = 1'b1;
      tick();
      check("pcol_after_a", data_a, 16'h2244);

      // Streaming reads of distinct words
      rd_en = 1'b0; wr_en = 1'b1; wr_be = 2'b11;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 3'(i); wr_data = val(i);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; rd_addr = 3'(i);
         tick();
         check($sformatf("strm_valid_a_%0d", i), 16'(valid_a), 16'd1);
         check($sformatf("strm_data_a_%0d", i), data_a, val(i));
         if (i > 0) check($sformatf("strm_data_b_%0d", i), data_b, val(i - 1));
      end
      rd_en = 1'b0;
      tick();
      check("strm_idle_valid_a", 16'(valid_a), 16'd0);
      check("strm_hold_data_a", data_a, val(7));
      check("strm_last_valid_b", 16'(valid_b), 16'd1);
      check("strm_last_data_b", data_b, val(7));
      tick();
      check("strm_idle_valid_b", 16'(valid_b), 16'd0);
      check("strm_hold_data_b", data_b, val(7));

      // Reset while a read is in flight in the two-stage pipeline
      rd_en = 1'b1; rd_addr = 3'd5;
      tick();
      rd_en = 1'b0; rst_n = 1'b0;
      #1;
      check("midrd_data_a", data_a, 16'h0000);
      check("midrd_data_b", data_b, 16'h0000);
      check("midrd_valid_b", 16'(valid_b), 16'd0);
      tick();
      check("midrd_later_valid_b", 16'(valid_b), 16'd0);

      // Reset at sweep count 4 restarts the sweep; user traffic ignored
      rst_n = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_be = 2'b11; wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr = 3'd2;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("resweep_busy_a_%0d", i), 16'(busy_a), 16'd1);
         tick();
         check($sformatf("resweep_valid_a_%0d", i), 16'(valid_a), 16'd0);
         check($sformatf("resweep_valid_b_%0d", i), 16'(valid_b), 16'd0);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      check("resweep_done_a", 16'(busy_a), 16'd0);
      check("resweep_done_b", 16'(busy_b), 16'd0);

      rd_en = 1'b1; rd_addr = 3'd2;
      tick();
      check("clr2_data_a", data_a, 16'h0000);
      rd_addr = 3'd7;
      tick();
      check("clr7_data_a", data_a, 16'h0000);
      check("clr2_valid_b", 16'(valid_b), 16'd1);
      check("clr2_data_b", data_b, 16'h0000);
      rd_en = 1'b0;
      tick();
      check("clr7_data_b", data_b, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
